csr_hpm_counters: RTL and testbench

Parametrised machine-mode counter/performance-monitor unit for the CSR block. It implements mcycle, minstret and up to 29 programmable mhpmcounters with event selectors, mcountinhibit and mcounteren. It also provides the user-mode read-only shadows (cycle/instret/hpmcounterN) with privilege checking. It replaces the fixed cycle/instret counters in the CSR unit with configurable width, counter count, event count and multi-retire increment.

---
 rtl/csr_hpm_counters.sv | 171 +++++++++++++++++
 tb/tb_csr_hpm_counters.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_hpm_counters.sv
// csr_hpm_counters: mcycle/minstret/mhpmcounterN with event selectors, mcountinhibit,
// mcounteren and privilege-checked user-mode read shadows.

module csr_hpm_cnt #(
  parameter int W     = 64,
  parameter int INC_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INC_W-1:0] inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      lo_data,
  input  logic [W-33:0]    hi_data,
  output logic [W-1:0]     cnt,
  output logic             ovf
);
  logic [W:0] sum;
  assign sum = {1'b0, cnt} + {{(W+1-INC_W){1'b0}}, inc};

  // A write replaces the increment for this cycle and never reports overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (wr_lo)      cnt <= {cnt[W-1:32], lo_data};
      else if (wr_hi) cnt <= {hi_data, cnt[31:0]};
      else begin
        cnt <= sum[W-1:0];
        ovf <= sum[W];
      end
    end
  end
endmodule

module csr_hpm_counters #(
  parameter int NUM_COUNTERS = 4,
  parameter int COUNTER_W    = 64,
  parameter int NUM_EVENTS   = 8,
  parameter int MAX_RETIRE   = 2,
  localparam int NC          = NUM_COUNTERS + 3,
  localparam int EVENT_SEL_W = $clog2(NUM_EVENTS + 1),
  localparam int RET_W       = $clog2(MAX_RETIRE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            priv_level,
  input  logic [NUM_EVENTS-1:0] event_valid,
  input  logic [RET_W-1:0]      retire_count,
  input  logic                  csr_read_en,
  input  logic [11:0]           csr_read_addr,
  output logic [31:0]           csr_read_data,
  output logic                  csr_read_valid,
  output logic                  csr_read_illegal,
  input  logic                  csr_write_en,
  input  logic [11:0]           csr_write_addr,
  input  logic [31:0]           csr_write_data,
  output logic                  csr_write_illegal,
  output logic [NC-1:0]         overflow
);
  typedef enum logic [2:0] {K_NONE, K_MCNT, K_UCNT, K_EVT, K_INH, K_EN} kind_e;

  localparam logic [NC-1:0] IMPL = ~NC'(2);

  function automatic kind_e decode(input logic [11:0] a);
    logic ctr_ok;
    ctr_ok = (a[6:5] == 2'b00) && (a[4:0] != 5'd1);
    if (a[11:8] == 4'hB && ctr_ok) return K_MCNT;
    if (a[11:8] == 4'hC && ctr_ok) return K_UCNT;
    if (a == 12'h320) return K_INH;
    if (a[11:5] == 7'h19 && a[4:0] >= 5'd3) return K_EVT;
    if (a == 12'h306) return K_EN;
    return K_NONE;
  endfunction

  logic [NC-1:0][COUNTER_W-1:0] cnt;
  logic [EVENT_SEL_W-1:0]       evt [NC];
  logic [NC-1:0]                mcountinhibit, mcounteren;
  logic [NUM_EVENTS:0]          ev_ext;
  kind_e                        wk, rk;
  logic                         wr_ok, m_mode;

  assign ev_ext            = {event_valid, 1'b0};
  assign m_mode            = (priv_level == 2'd3);
  assign wk                = decode(csr_write_addr);
  assign csr_write_illegal = csr_write_en && (wk == K_NONE || wk == K_UCNT);
  assign wr_ok             = csr_write_en && !csr_write_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcountinhibit <= '0;
      mcounteren    <= '0;
      for (int i = 0; i < NC; i++) evt[i] <= '0;
    end else if (wr_ok) begin
      if (wk == K_INH) mcountinhibit <= csr_write_data[NC-1:0] & IMPL;
      if (wk == K_EN)  mcounteren    <= csr_write_data[NC-1:0] & IMPL;
      for (int i = 3; i < NC; i++)
        if (wk == K_EVT && csr_write_addr[4:0] == 5'(i))
          evt[i] <= (csr_write_data > 32'(NUM_EVENTS)) ? '0 : csr_write_data[EVENT_SEL_W-1:0];
    end
  end

  for (genvar i = 0; i < NC; i++) begin : g_ctr
    if (i == 1) begin : g_time
      assign cnt[i]      = '0;
      assign overflow[i] = 1'b0;
    end else begin : g_cnt
      logic [RET_W-1:0] inc;
      logic             hit_lo, hit_hi;
      if (i == 0)      assign inc = RET_W'(!mcountinhibit[0]);
      else if (i == 2) assign inc = mcountinhibit[2] ? '0 : retire_count;
      else             assign inc = RET_W'(ev_ext[evt[i]] && !mcountinhibit[i]);
      assign hit_lo = wr_ok && wk == K_MCNT && csr_write_addr[4:0] == 5'(i) && !csr_write_addr[7];
      assign hit_hi = wr_ok && wk == K_MCNT && csr_write_addr[4:0] == 5'(i) &&  csr_write_addr[7];
      csr_hpm_cnt #(.W(COUNTER_W), .INC_W(RET_W)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (inc),
        .wr_lo   (hit_lo),
        .wr_hi   (hit_hi),
        .lo_data (csr_write_data),
        .hi_data (csr_write_data[COUNTER_W-33:0]),
        .cnt     (cnt[i]),
        .ovf     (overflow[i])
      );
    end
  end

  logic [63:0] cnt_sel;
  logic [31:0] half, rd_val;
  logic        en_bit, rd_ill;
  logic [EVENT_SEL_W-1:0] evt_sel;

  always_comb begin
    rk      = decode(csr_read_addr);
    cnt_sel = '0;
    en_bit  = 1'b0;
    evt_sel = '0;
    for (int i = 0; i < NC; i++)
      if (csr_read_addr[4:0] == 5'(i)) begin
        cnt_sel = 64'(cnt[i]);
        en_bit  = mcounteren[i];
        evt_sel = evt[i];
      end
    half   = csr_read_addr[7] ? cnt_sel[63:32] : cnt_sel[31:0];
    rd_ill = 1'b0;
    rd_val = '0;
    case (rk)
      K_MCNT:  begin rd_ill = !m_mode;            rd_val = half;               end
      K_UCNT:  begin rd_ill = !m_mode && !en_bit; rd_val = half;               end
      K_EVT:   begin rd_ill = !m_mode;            rd_val = 32'(evt_sel);       end
      K_INH:   begin rd_ill = !m_mode;            rd_val = 32'(mcountinhibit); end
      K_EN:    begin rd_ill = !m_mode;            rd_val = 32'(mcounteren);    end
      default: rd_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_read_data    <= '0;
      csr_read_valid   <= 1'b0;
      csr_read_illegal <= 1'b0;
    end else begin
      csr_read_valid   <= csr_read_en;
      csr_read_illegal <= csr_read_en && rd_ill;
      if (csr_read_en) csr_read_data <= rd_ill ? '0 : rd_val;
    end
  end
endmodule

// File: tb/tb_csr_hpm_counters.sv
// Randomised scoreboard bench for csr_hpm_counters against an arithmetic reference model.
module tb_csr_hpm_counters;
  localparam int NUM_COUNTERS = 4;
  localparam int COUNTER_W    = 64;
  localparam int NUM_EVENTS   = 8;
  localparam int MAX_RETIRE   = 2;
  localparam int NC           = NUM_COUNTERS + 3;
  localparam int RET_W        = $clog2(MAX_RETIRE + 1);
  localparam logic [63:0] MASK = {64{1'b1}} >> (64 - COUNTER_W);

  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] priv;
  logic [NUM_EVENTS-1:0] ev;
  logic [RET_W-1:0] rc;
  logic rd_en, wr_en, rd_valid, rd_ill, wr_ill;
  logic [11:0] rd_addr, wr_addr;
  logic [31:0] rd_data, wr_data;
  logic [NC-1:0] ovf;

  csr_hpm_counters #(.NUM_COUNTERS(NUM_COUNTERS), .COUNTER_W(COUNTER_W),
                     .NUM_EVENTS(NUM_EVENTS), .MAX_RETIRE(MAX_RETIRE)) dut (
    .clk(clk), .rst_n(rst_n), .priv_level(priv), .event_valid(ev), .retire_count(rc),
    .csr_read_en(rd_en), .csr_read_addr(rd_addr), .csr_read_data(rd_data),
    .csr_read_valid(rd_valid), .csr_read_illegal(rd_ill),
    .csr_write_en(wr_en), .csr_write_addr(wr_addr), .csr_write_data(wr_data),
    .csr_write_illegal(wr_ill), .overflow(ovf)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [32:0] exp_q [$];
  logic [63:0] m_cnt [32];
  int          m_evt [32];
  logic [31:0] m_inh, m_en, m_impl;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 32; k++) begin m_cnt[k] = '0; m_evt[k] = 0; end
    m_inh = '0; m_en = '0; m_impl = '0;
    for (int k = 0; k < NC; k++) if (k != 1) m_impl[k] = 1'b1;
  endtask

  function automatic logic [31:0] m_half(input int n, input bit hi);
    logic [63:0] v;
    v = m_cnt[n];
    return hi ? v[63:32] : v[31:0];
  endfunction

  // {illegal, data} for a read issued now, from the architectural rules
  function automatic logic [32:0] m_read(input logic [11:0] a, input logic [1:0] p);
    int n;
    bit mm;
    n = int'(a[4:0]);
    mm = (p == 2'd3);
    if (((a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F)) && n != 1)
      return mm ? {1'b0, m_half(n, a >= 12'hB80)} : 33'h1_0000_0000;
    if (((a >= 12'hC00 && a <= 12'hC1F) || (a >= 12'hC80 && a <= 12'hC9F)) && n != 1)
      return (mm || m_en[n]) ? {1'b0, m_half(n, a >= 12'hC80)} : 33'h1_0000_0000;
    if (a == 12'h320) return mm ? {1'b0, m_inh} : 33'h1_0000_0000;
    if (a == 12'h306) return mm ? {1'b0, m_en} : 33'h1_0000_0000;
    if (a >= 12'h323 && a <= 12'h33F) return mm ? {1'b0, 32'(m_evt[n])} : 33'h1_0000_0000;
    return 33'h1_0000_0000;
  endfunction

  function automatic bit m_wlegal(input logic [11:0] a);
    if (((a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F)) && a[4:0] != 5'd1)
      return 1'b1;
    return a == 12'h320 || a == 12'h306 || (a >= 12'h323 && a <= 12'h33F);
  endfunction

  // One clock: drive the request, check combinational write fault, advance model, check overflow.
  task automatic cyc(input bit rd, input logic [11:0] ra, input bit wr,
                     input logic [11:0] wa, input logic [31:0] wd);
    logic [NC-1:0] eo;
    logic [64:0] s;
    int inc, n;
    bit wl;
    rd_en = rd; rd_addr = ra; wr_en = wr; wr_addr = wa; wr_data = wd;
    if (rd) exp_q.push_back(m_read(ra, priv));
    wl = wr && m_wlegal(wa);
    #1 chk("wr_illegal", 64'(wr_ill), 64'(wr && !wl));
    @(posedge clk);
    eo = '0;
    for (int k = 0; k < NC; k++) if (k != 1) begin
      if (k == 0)      inc = m_inh[0] ? 0 : 1;
      else if (k == 2) inc = m_inh[2] ? 0 : int'(rc);
      else             inc = (m_evt[k] != 0 && ev[m_evt[k]-1] && !m_inh[k]) ? 1 : 0;
      if (wl && wa == 12'hB00 + 12'(k))      m_cnt[k] = {m_cnt[k][63:32], wd};
      else if (wl && wa == 12'hB80 + 12'(k)) m_cnt[k] = {wd, m_cnt[k][31:0]} & MASK;
      else begin
        s = {1'b0, m_cnt[k]} + 65'(inc);
        eo[k] = s[COUNTER_W];
        m_cnt[k] = s[63:0] & MASK;
      end
    end
    if (wl) begin
      n = int'(wa[4:0]);
      if (wa == 12'h320) m_inh = wd & m_impl;
      if (wa == 12'h306) m_en = wd & m_impl;
      if (wa >= 12'h323 && wa <= 12'h33F && n < NC) m_evt[n] = (wd > NUM_EVENTS) ? 0 : int'(wd);
    end
    #1 chk("overflow", 64'(ovf), 64'(eo));
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && rd_valid) begin
      if (exp_q.size() == 0) chk("rd_unexpected", 64'(rd_valid), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("rd_data", 64'(rd_data), 64'(e[31:0]));
        chk("rd_illegal", 64'(rd_ill), 64'(e[32]));
      end
    end
  end

  logic [11:0] addrs [24] = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB06, 12'hB07, 12'hB80,
                             12'hB82, 12'hB83, 12'hB01, 12'hC00, 12'hC02, 12'hC03, 12'hC83,
                             12'hC07, 12'h320, 12'h323, 12'h324, 12'h328, 12'h306, 12'h321,
                             12'h000, 12'hFFF, 12'hC01};
  logic [1:0] privs [3] = '{2'd0, 2'd1, 2'd3};

  initial begin
    bit rd, wr;
    logic [31:0] wd;
    priv = 2'd3; ev = '0; rc = '0;
    rd_en = 0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    m_reset();
    #12;
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_illegal", 64'(rd_ill), 64'd0);
    chk("rst_overflow", 64'(ovf), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    repeat (10) cyc(0, 0, 0, 0, 0);
    cyc(1, 12'hB00, 0, 0, 0);
    cyc(1, 12'hB02, 0, 0, 0);

    rc = 2; repeat (5) cyc(0, 0, 0, 0, 0);
    rc = 0; cyc(0, 0, 1, 12'h320, 32'h4);
    rc = 2; repeat (3) cyc(0, 0, 0, 0, 0);
    rc = 0; cyc(1, 12'hB02, 1, 12'h320, 32'h0);

    cyc(0, 0, 1, 12'h323, 32'd2);
    ev = 8'h02; repeat (7) cyc(0, 0, 0, 0, 0);
    ev = 8'h01; repeat (4) cyc(0, 0, 0, 0, 0);
    ev = 8'h00; cyc(1, 12'hB03, 1, 12'h323, 32'(NUM_EVENTS + 1));
    cyc(1, 12'h323, 1, 12'h323, 32'd2);

    cyc(0, 0, 1, 12'hB80, 32'hFFFF_FFFF);
    cyc(0, 0, 1, 12'hB00, 32'hFFFF_FFFE);
    repeat (4) cyc(1, 12'hB00, 0, 0, 0);

    ev = 8'h02; cyc(0, 0, 1, 12'hB03, 32'h1234);
    ev = 8'h00; cyc(1, 12'hB03, 1, 12'hB83, 32'hABCD);
    cyc(1, 12'hB83, 0, 0, 0);
    cyc(1, 12'hB03, 0, 0, 0);

    priv = 2'd0;
    cyc(0, 0, 1, 12'h306, 32'h0);
    cyc(1, 12'hC00, 0, 0, 0);
    cyc(0, 0, 1, 12'h306, 32'h1);
    cyc(1, 12'hC00, 0, 0, 0);
    cyc(1, 12'hC02, 1, 12'hC00, 32'h5);
    priv = 2'd3;
    cyc(1, 12'hB00, 0, 0, 0);

    cyc(0, 0, 1, 12'hB82, 32'hFFFF_FFFF);
    cyc(0, 0, 1, 12'hB02, 32'hFFFF_FFFF);
    rc = 2; cyc(0, 0, 0, 0, 0);
    rc = 0; cyc(1, 12'hB02, 0, 0, 0);
    cyc(1, 12'hB00, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // asynchronous reset in the middle of a cycle
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rd_data", 64'(rd_data), 64'd0);
    chk("midrst_overflow", 64'(ovf), 64'd0);
    m_reset();
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    cyc(1, 12'hB00, 0, 0, 0);
    cyc(1, 12'h306, 0, 0, 0);

    repeat (400) begin
      priv = privs[$urandom_range(0, 2)];
      ev = NUM_EVENTS'($urandom);
      rc = RET_W'($urandom_range(0, MAX_RETIRE));
      rd = ($urandom_range(0, 1) == 1);
      wr = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: wd = $urandom;
        1: wd = 32'hFFFF_FFFF;
        2: wd = $urandom_range(0, 15);
        default: wd = 32'hFFFF_FFFE;
      endcase
      cyc(rd, addrs[$urandom_range(0, 23)], wr, addrs[$urandom_range(0, 23)], wd);
    end

    priv = 2'd3; ev = '0; rc = '0;
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
